// File: rtl/seq_stim_driver_pkg.sv
// rtl/seq_stim_driver_pkg.sv - shared types and constants for the sequencer stimulus driver
//
// Purpose: state codes of the five-state example sequencer (reused for step),
// the driver FSM state enum and the D values that advance the sequencer.
package seq_stim_driver_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } seq_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRIVE = 2'd2,
    FINAL = 2'd3
  } drv_state_t;

  localparam logic [3:0] D_ADV_S1 = 4'b0001;
  localparam logic [3:0] D_ADV_S3 = 4'b1111;

endpackage

// File: rtl/seq_stim_cond.sv
// rtl/seq_stim_cond.sv - combinational map from sequencer step to its advance condition
//
// Ports:
//   step     in  3  sequencer code whose advance condition is wanted
//   a, b, c  out 1  stimulus bits for that step
//   d        out 4  stimulus nibble for that step
// Codes outside S0..S3 map to all-zero stimulus.
module seq_stim_cond
  import seq_stim_driver_pkg::*;
(
  input  logic [2:0] step,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [3:0] d
);

  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 4'b0000;
    case (step)
      S0: a = 1'b1;
      S1: d = D_ADV_S1;
      S2: begin
        a = 1'b1;
        b = 1'b1;
        c = 1'b1;
      end
      S3: d = D_ADV_S3;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_stim_driver.sv
// rtl/seq_stim_driver.sv - walks the five-state example sequencer through one cycle and checks Q
//
// Ports:
//   clk        in  1  rising-edge clock
//   rstN       in  1  asynchronous active-low reset
//   start      in  1  run request, sampled only in IDLE
//   Q          in  3  state code returned by the sequencer
//   A, B, C    out 1  registered stimulus
//   D          out 4  registered stimulus
//   busy       out 1  run in progress
//   done       out 1  one-cycle pulse at the end of a run (pass or abort)
//   err        out 1  sticky failure flag, cleared by the next accepted start
//   step       out 3  expected sequencer code for the current step
// Parameters: HOLD_CYCLES (>=1) check cycles per step, TIMEOUT drive-cycle limit.
// Optional feature: define SEQ_STIM_WATCHDOG_EN to abort a step stuck in DRIVE
// after TIMEOUT cycles.
module seq_stim_driver
  import seq_stim_driver_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic [2:0] Q,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] step
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  drv_state_t state, nxt_state;
  logic [7:0] hold_cnt, nxt_hold_cnt;
  logic [2:0] nxt_step;
  logic       nxt_busy, nxt_done, nxt_err;
  logic       nxt_drive;
  logic       abort;
  logic       cond_a, cond_b, cond_c;
  logic [3:0] cond_d;

`ifdef SEQ_STIM_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt, nxt_wd_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // Stimulus only ever depends on the current step: whenever the next state
  // is DRIVE, step is not changing on this edge.
  seq_stim_cond u_cond (
    .step (step),
    .a    (cond_a),
    .b    (cond_b),
    .c    (cond_c),
    .d    (cond_d)
  );

  always_comb begin
    nxt_state    = state;
    nxt_hold_cnt = hold_cnt;
    nxt_step     = step;
    nxt_busy     = busy;
    nxt_done     = 1'b0;
    nxt_err      = err;
    nxt_drive    = 1'b0;
    abort        = 1'b0;
`ifdef SEQ_STIM_WATCHDOG_EN
    nxt_wd_cnt   = wd_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state    = HOLD;
          nxt_step     = S0;
          nxt_err      = 1'b0;
          nxt_busy     = 1'b1;
          nxt_hold_cnt = 8'd0;
        end
      end
      HOLD: begin
        if (Q != step) begin
          abort = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          nxt_state    = DRIVE;
          nxt_hold_cnt = 8'd0;
          nxt_drive    = 1'b1;
`ifdef SEQ_STIM_WATCHDOG_EN
          nxt_wd_cnt   = 16'd0;
`endif
        end else begin
          nxt_hold_cnt = hold_cnt + 8'd1;
        end
      end
      DRIVE: begin
        if (Q == step + 3'd1) begin
          nxt_step  = step + 3'd1;
          nxt_state = (step == S3) ? FINAL : HOLD;
        end else if (Q == step) begin
`ifdef SEQ_STIM_WATCHDOG_EN
          if (wd_cnt == WD_LAST) begin
            abort = 1'b1;
          end else begin
            nxt_wd_cnt = wd_cnt + 16'd1;
            nxt_drive  = 1'b1;
          end
`else
          nxt_drive = 1'b1;
`endif
        end else begin
          abort = 1'b1;
        end
      end
      FINAL: begin
        // S4 returns to S0 unconditionally, so one observation decides the run.
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
        nxt_done  = 1'b1;
        if (Q == S0) begin
          nxt_step = S0;
        end else begin
          nxt_err = 1'b1;
        end
      end
    endcase
    // Abort keeps step at the failing value so it can be read back.
    if (abort) begin
      nxt_state = IDLE;
      nxt_busy  = 1'b0;
      nxt_done  = 1'b1;
      nxt_err   = 1'b1;
      nxt_drive = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      step     <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      A        <= 1'b0;
      B        <= 1'b0;
      C        <= 1'b0;
      D        <= 4'b0000;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_hold_cnt;
      step     <= nxt_step;
      busy     <= nxt_busy;
      done     <= nxt_done;
      err      <= nxt_err;
      A        <= nxt_drive & cond_a;
      B        <= nxt_drive & cond_b;
      C        <= nxt_drive & cond_c;
      D        <= nxt_drive ? cond_d : 4'b0000;
    end
  end

`ifdef SEQ_STIM_WATCHDOG_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wd_cnt <= 16'd0;
    end else begin
      wd_cnt <= nxt_wd_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_seq_stim_driver.sv
// tb/tb_seq_stim_driver.sv - scoreboard bench for seq_stim_driver against a behavioural sequencer
module tb_seq_stim_driver;

  localparam int H  = 2;
  localparam int P  = H + 2;
  localparam int TO = 4;

  typedef struct {
    int cyc;
    int err;
    int step;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       seq_rstn;
  logic       start;
  logic       qforce_en;
  logic [2:0] qforce_val;
  logic [2:0] seq_q;
  logic [2:0] dut_q;
  logic       A, B, C, busy, done, err;
  logic [3:0] D;
  logic [2:0] step;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural five-state sequencer: S0 -A-> S1 -D==1-> S2 -ABC-> S3 -D==F-> S4 -> S0
  always @(posedge clk or negedge rstN or negedge seq_rstn) begin
    if (!rstN || !seq_rstn) seq_q <= 3'd0;
    else begin
      case (seq_q)
        3'd0: if (A) seq_q <= 3'd1;
        3'd1: if (D == 4'b0001) seq_q <= 3'd2;
        3'd2: if (A && B && C) seq_q <= 3'd3;
        3'd3: if (D == 4'b1111) seq_q <= 3'd4;
        default: seq_q <= 3'd0;
      endcase
    end
  end

  assign dut_q = qforce_en ? qforce_val : seq_q;

  seq_stim_driver #(.HOLD_CYCLES(H), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .Q     (dut_q),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .step  (step)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected {A,B,C,D} t edges after the start edge of an undisturbed run:
  // each step spends H cycles idle and 2 cycles with its advance condition held.
  function automatic logic [6:0] exp_stim(input int t);
    int k = t / P;
    int r = t % P;
    if (k > 3 || r < H) return 7'd0;
    case (k)
      0: return 7'b100_0000;
      1: return 7'b000_0001;
      2: return 7'b111_0000;
      default: return 7'b000_1111;
    endcase
  endfunction

  function automatic int exp_step_at(input int t);
    return (t < 4 * P) ? t / P : 4;
  endfunction

  // lat: edges from start edge to done (0 = never ends); f_t/fv: force Q=fv at
  // edge f_t (from f_t onward when stuck); rs_t: extra start pulse edge;
  // rst_t: async reset just before that edge.
  task automatic do_run(input int lat, input int e_err, input int e_step, input int f_t,
                        input int fv, input bit stuck, input int rs_t, input bit chk_stim,
                        input int rst_t);
    int start_edge;
    int last;
    start = 1'b1;
    start_edge = cyc + 1;
    if (rst_t == 0 && lat > 0) sb.push_back('{start_edge + lat, e_err, e_step});
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    chk("start_step", step, 0);
    last = (rst_t > 0) ? rst_t - 1 : ((lat > 0) ? lat + 1 : 40);
    for (int t = 1; t <= last; t++) begin
      qforce_en  = (t == f_t) || (stuck && t >= f_t);
      qforce_val = 3'(fv);
      start      = (t == rs_t);
      @(posedge clk); #1;
      if (chk_stim && t <= 4 * P) begin
        chk("stimulus", {A, B, C, D}, exp_stim(t));
        chk("step_mid_run", step, exp_step_at(t));
      end
    end
    qforce_en = 1'b0;
    start     = 1'b0;
    if (rst_t > 0) begin
      #2 rstN = 1'b0;
      #1 chk("async_reset_outputs", {A, B, C, D, busy, done, err, step}, 0);
      @(posedge clk); #1;
      rstN = 1'b1;
    end else if (lat == 0) begin
      chk("stuck_busy", busy, 1);
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
    end
    seq_rstn = 1'b0;
    @(posedge clk); #1;
    seq_rstn = 1'b1;
  endtask

  // Monitor: every cycle either an expected done is due or done must be low.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        mon_e = sb.pop_front();
        chk("done_at_cycle", done, 1);
        chk("done_err", err, mon_e.err);
        chk("done_step", step, mon_e.step);
        chk("done_busy_low", busy, 0);
        chk("done_stim_zero", {A, B, C, D}, 0);
      end else begin
        chk("no_spurious_done", done, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int typ, k, j, lat, ee, es, ft, fv, rs;
    bit cs;
    rstN = 1'b0;
    seq_rstn = 1'b1;
    start = 1'b0;
    qforce_en = 1'b0;
    qforce_val = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {A, B, C, D, busy, done, err, step}, 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    do_run(4 * P + 1, 0, 0, 0, 0, 1'b0, 0, 1'b1, 0);       // clean run, done at 17
    do_run(1, 1, 0, 1, 2, 1'b0, 0, 1'b0, 0);               // Q=010 in step-0 HOLD
    do_run(4 * P + 1, 1, 4, 4 * P + 1, 4, 1'b0, 0, 1'b0, 0); // Q stays 100 in FINAL
    do_run(4 * P + 1, 0, 0, 0, 0, 1'b0, 5, 1'b1, 0);       // start re-pulse ignored
    do_run(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 9);               // reset mid-run
    do_run(4 * P + 1, 0, 0, 0, 0, 1'b0, 0, 1'b1, 0);       // normal run after reset
`ifdef SEQ_STIM_WATCHDOG_EN
    do_run(P + H + TO, 1, 1, P + H + 1, 1, 1'b1, 0, 1'b0, 0);
`else
    do_run(0, 0, 0, P + H + 1, 1, 1'b1, 0, 1'b0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      typ = int'($urandom_range(0, 4));
      k = 0; j = 0; ft = 0; fv = 0; ee = 0; es = 0; cs = 1'b0;
      case (typ)
        0: begin lat = 4 * P + 1; cs = 1'b1; end
        1: begin
          k = int'($urandom_range(0, 3)); j = int'($urandom_range(1, H));
          ft = P * k + j; fv = (k + int'($urandom_range(1, 7))) % 8;
          lat = ft; ee = 1; es = k;
        end
        2: begin
          k = int'($urandom_range(0, 3)); ft = P * k + H + 1;
          fv = (k + int'($urandom_range(2, 7))) % 8;
          lat = ft; ee = 1; es = k;
        end
        3: begin
          ft = 4 * P + 1; fv = int'($urandom_range(1, 7));
          lat = ft; ee = 1; es = 4;
        end
        default: begin
          // Q lags one extra cycle at the observe edge: the step simply stretches.
          k = int'($urandom_range(0, 2)); ft = P * k + H + 2; fv = k;
          lat = 4 * P + 2;
        end
      endcase
      rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat)) : 0;
      do_run(lat, ee, es, ft, fv, 1'b0, rs, cs, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stim_driver.md
# seq_stim_driver

Stimulus initiator for the five-state example sequencer (S0→S4→S0), which advances on A, D==4'b0001, A&B&C and D==4'b1111 and reports its state code on Q. On a start request the block drives A/B/C/D to walk that sequencer through one full cycle. It checks the returned Q at every step and reports completion and errors. It sits beside the sequencer in self-test and integration benches and in on-chip bring-up logic.

## Interface
- HOLD_CYCLES, 2: idle-stimulus cycles per step before the advance condition is driven; legal range ≥1.
- TIMEOUT, 16: maximum DRIVE cycles per step before an error; used only with the watchdog macro.
- clk  in  1  rising-edge clock.
- rstN  in  1  reset, asynchronous, active-low.
- start  in  1  one run is requested when start=1 is sampled in IDLE.
- Q  in  3  state code returned by the sequencer (S0=000 … S4=100).
- A, B, C  out  1 each  registered stimulus.
- D  out  4  registered stimulus.
- busy  out  1  high from the start-sampling edge until done.
- done  out  1  one-cycle pulse when a run ends, on pass or abort.
- err  out  1  sticky fail flag; cleared by reset or by the next accepted start.
- step  out  3  expected sequencer code for the current step.

## Operation
- Driver FSM states: IDLE, HOLD, DRIVE, FINAL.
- Reset: state=IDLE. A=B=C=0, D=0, busy=0, done=0, err=0, step=000, counters=0.
- IDLE: all stimulus is 0. start=1 → HOLD, step=000, err=0, busy=1. start while busy is ignored.
- HOLD: stimulus is 0 and Q is compared with step every cycle.
  - Any mismatch sets err and aborts.
  - After HOLD_CYCLES matching cycles → DRIVE.
- DRIVE: the advance condition for step k is held:
  - k=0: A=1.
  - k=1: D=0001.
  - k=2: A=B=C=1.
  - k=3: D=1111.
- DRIVE response to Q:
  - Q==step: keep driving.
  - Q==step+1: clear stimulus and step++. Go to HOLD when k<3, or to FINAL when k=3.
  - Any other Q: err and abort.
- FINAL: Q must read 000 on the next cycle, because S4 returns unconditionally. Match → pass. Otherwise → err.
- Abort or pass: stimulus cleared, done pulsed, busy=0, then IDLE. On pass err stays 0; on abort err=1.
- step after the run: 000 on pass; on abort it holds the failing step.
- Stimulus held one extra cycle after the transition is harmless by construction: every driven condition is ignored by the next sequencer state.

## Timing
- All outputs are registered and change only on the clk rising edge, except for asynchronous reset.
- Run latency against a conforming sequencer: done is high in cycle 4·(HOLD_CYCLES+2)+1 after the start-sampling edge (17 with the default). busy falls in the same cycle.
- Per step: HOLD_CYCLES check cycles, then 1 drive cycle for the sequencer to register the transition, then 1 cycle to observe the new Q.
- An abort ends the run at the first cycle the failure is detected; done is high on the next cycle.
- rstN low during a run: immediate return to IDLE, all outputs 0, no done pulse.

## Configuration
- SEQ_STIM_WATCHDOG_EN defined: a DRIVE cycle counter runs. If TIMEOUT cycles pass in DRIVE without Q==step+1, err is set and the run aborts. The counter clears on entry to every DRIVE.
- Macro undefined: no counter and no TIMEOUT use. DRIVE waits indefinitely while Q==step.

## Structure
- Package common: the existing sequencer state enum (S0–S4 codes), reused for step; a new driver-state enum (IDLE, HOLD, DRIVE, FINAL); localparams for the advance D codes 4'b0001 and 4'b1111.
- Optional sub-module seq_stim_cond: a combinational map from step to {A,B,C,D}.
- The whole block is otherwise one module.

## Test plan
- Connect to the real sequencer with HOLD_CYCLES=2 and pulse start → A, D=0001, ABC=111 and D=1111 are driven in order; done at cycle 17; err=0; step returns to 000.
- Force Q=010 during step-0 HOLD → err=1 and done in the next cycle; step=000; all stimulus 0.
- Watchdog on, TIMEOUT=4, Q stuck at 001 → abort after 4 DRIVE cycles of step 1 with err=1. With the macro off → busy stays high and no done.
- Deassert rstN at cycle 9 of a run → outputs 0 asynchronously; a new start afterwards completes normally in 17 cycles.
- Pulse start again at cycle 5 of a run → ignored; a single done at cycle 17.
- After step 3, Q stays 100 instead of returning to 000 → err=1 from FINAL, then a single done pulse.
